// File: rtl/perf_trace_pkg.sv
// Shared types for the pipeline trace source: trace record, FSM states and the
// sequential PC-select code that qualifies a stall.
package perf_trace_pkg;

  localparam int TRC_CNT_W = 16;
  localparam logic [1:0] PC_CTRL_SEQ = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } trc_state_e;

  typedef struct packed {
    logic [TRC_CNT_W-1:0] cycle;
    logic [31:0]          pc;
    logic [TRC_CNT_W-1:0] stall;
    logic [TRC_CNT_W-1:0] flush;
  } trc_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; a push into a full FIFO is accepted when a
// pop happens on the same edge. The head reads as zero while empty.
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    pop_data = '0;
    if (!empty) pop_data = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/perf_trace_unit.sv
// Pipeline trace source: counts stalls/flushes per captured cycle and streams
// records through a FIFO. Define PERF_TRACE_FILTER_EN to record hazard cycles only.
module perf_trace_unit
  import perf_trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = TRC_CNT_W,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       pc_ctrl_i,
  output logic             trc_valid_o,
  input  logic             trc_ready_i,
  output logic [CNT_W-1:0] trc_cycle_o,
  output logic [31:0]      trc_pc_o,
  output logic [CNT_W-1:0] trc_stall_o,
  output logic [CNT_W-1:0] trc_flush_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  trc_state_e       state;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, drop_cnt;
  logic [CNT_W-1:0] stall_nxt, flush_nxt;
  logic             overflow, done;
  logic             capture, stall_hit, flush_hit, push_req, pop, drop;
  logic             full, empty;
  trc_rec_t         rec_in, rec_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // The IDLE->RUN edge already captures cycle 0.
  assign capture   = start && ((state == ST_IDLE) || (state == ST_RUN));
  assign stall_hit = stall_i && (pc_ctrl_i == PC_CTRL_SEQ);
  assign flush_hit = flush_i;
  assign stall_nxt = sat_inc(stall_cnt, stall_hit);
  assign flush_nxt = sat_inc(flush_cnt, flush_hit);

`ifdef PERF_TRACE_FILTER_EN
  assign push_req = capture && (stall_hit || flush_hit);
`else
  assign push_req = capture;
`endif

  assign pop  = trc_valid_o && trc_ready_i;
  assign drop = push_req && full && !pop;

  assign rec_in = '{cycle: TRC_CNT_W'(cycle_cnt), pc: pc_i,
                    stall: TRC_CNT_W'(stall_nxt), flush: TRC_CNT_W'(flush_nxt)};

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trc_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (rec_head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (capture) begin
        cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
        stall_cnt <= stall_nxt;
        flush_cnt <= flush_nxt;
      end
      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt, 1'b1);
        overflow <= 1'b1;
      end
      case (state)
        ST_IDLE:  if (start) state <= (cycle_cnt == LAST_CYCLE) ? ST_DRAIN : ST_RUN;
        ST_RUN:   if (start && (cycle_cnt == LAST_CYCLE)) state <= ST_DRAIN;
        ST_DRAIN: if (empty) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE:  ;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign trc_valid_o = !empty;
  assign trc_cycle_o = CNT_W'(rec_head.cycle);
  assign trc_pc_o    = rec_head.pc;
  assign trc_stall_o = CNT_W'(rec_head.stall);
  assign trc_flush_o = CNT_W'(rec_head.flush);
  assign overflow_o  = overflow;
  assign drop_cnt_o  = drop_cnt;
  assign done_o      = done;

endmodule

// File: tb/tb_perf_trace_unit.sv
// Scoreboard bench for perf_trace_unit: a queue-based reference model predicts
// each record and a forked monitor checks every pop against it.
module tb_perf_trace_unit;

  localparam int DEPTH      = 8;
  localparam int CNT_W      = 16;
  localparam int MAX_CYCLES = 30;
  localparam int SAT        = (1 << CNT_W) - 1;

  typedef struct {
    int          cycle;
    logic [31:0] pc;
    int          stall;
    int          flush;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      pc_i = '0;
  logic             stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [1:0]       pc_ctrl_i = '0;
  logic             trc_ready_i = 1'b0;
  logic             trc_valid_o;
  logic [CNT_W-1:0] trc_cycle_o;
  logic [31:0]      trc_pc_o;
  logic [CNT_W-1:0] trc_stall_o;
  logic [CNT_W-1:0] trc_flush_o;
  logic             overflow_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             done_o;

  perf_trace_unit #(
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_i        (pc_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pc_ctrl_i   (pc_ctrl_i),
    .trc_valid_o (trc_valid_o),
    .trc_ready_i (trc_ready_i),
    .trc_cycle_o (trc_cycle_o),
    .trc_pc_o    (trc_pc_o),
    .trc_stall_o (trc_stall_o),
    .trc_flush_o (trc_flush_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t pend;
  bit   pend_v = 1'b0;
  // Reference model: phase 0 before the run, 1 running, 2 run finished.
  int   m_phase, m_cycle, m_stall, m_flush, m_drop;
  bit   m_ovf;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("valid", trc_valid_o, exp_q.size() != 0);
        if (trc_valid_o && trc_ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rec_cycle", trc_cycle_o, e.cycle);
          chk("rec_pc",    trc_pc_o,    e.pc);
          chk("rec_stall", trc_stall_o, e.stall);
          chk("rec_flush", trc_flush_o, e.flush);
        end
      end
    end
  endtask

  // One clock of stimulus; the model predicts what the FIFO holds after the edge.
  task automatic step(input bit st, input logic [31:0] pc, input bit stl, input bit fl,
                      input logic [1:0] pcc, input bit rdy);
    bit hs, hf, push, pop_now;
    @(posedge clk); #1;
    if (pend_v) begin
      exp_q.push_back(pend);
      pend_v = 1'b0;
    end
    start = st; pc_i = pc; stall_i = stl; flush_i = fl; pc_ctrl_i = pcc; trc_ready_i = rdy;
    pop_now = rdy && (exp_q.size() != 0);
    if (st && m_phase != 2) begin
      hs = stl && (pcc == 2'b00);
      hf = fl;
      if (hs && m_stall < SAT) m_stall++;
      if (hf && m_flush < SAT) m_flush++;
`ifdef PERF_TRACE_FILTER_EN
      push = hs || hf;
`else
      push = 1'b1;
`endif
      if (push) begin
        if (exp_q.size() == DEPTH && !pop_now) begin
          if (m_drop < SAT) m_drop++;
          m_ovf = 1'b1;
        end else begin
          pend   = '{m_cycle, pc, m_stall, m_flush};
          pend_v = 1'b1;
        end
      end
      m_phase = (m_cycle == MAX_CYCLES - 1) ? 2 : 1;
      if (m_cycle < SAT) m_cycle++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; stall_i = 1'b0; flush_i = 1'b0; trc_ready_i = 1'b0;
    exp_q.delete();
    pend_v = 1'b0;
    m_phase = 0; m_cycle = 0; m_stall = 0; m_flush = 0; m_drop = 0; m_ovf = 1'b0;
    #2;
    chk("rst_valid",    trc_valid_o, 0);
    chk("rst_overflow", overflow_o,  0);
    chk("rst_done",     done_o,      0);
    chk("rst_cycle",    trc_cycle_o, 0);
    chk("rst_pc",       trc_pc_o,    0);
    chk("rst_stall",    trc_stall_o, 0);
    chk("rst_flush",    trc_flush_o, 0);
    chk("rst_drop",     drop_cnt_o,  0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // mode 0 free run, 1 directed hazards, 2 full backpressure, 3 random
  task automatic run(input int mode, input int n_steps, input int gap_at, input int gap_len);
    for (int k = 0; k < n_steps; k++) begin
      bit          st;
      int          c;
      logic [31:0] pc;
      bit          stl, fl, rdy;
      logic [1:0]  pcc;
      st  = !(k >= gap_at && k < gap_at + gap_len);
      c   = m_cycle;
      pc  = 32'(4 * c);
      stl = 1'b0; fl = 1'b0; rdy = 1'b1; pcc = 2'b00;
      case (mode)
        1: begin
          stl = (c == 3 || c == 4);
          pcc = (c == 4) ? 2'b01 : 2'b00;
          fl  = (c == 7);
        end
        2: rdy = 1'b0;
        3: begin
          pc  = $urandom;
          stl = ($urandom_range(0, 3) == 0);
          fl  = ($urandom_range(0, 5) == 0);
          pcc = 2'($urandom_range(0, 2));
          rdy = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
      step(st, pc, stl, fl, pcc, rdy);
    end
  endtask

  // Drain with ready held high, then check drop state and the done timing.
  task automatic finish_run();
    int n = 0;
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1);
    while ((exp_q.size() != 0 || pend_v) && n < 100) begin
      step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1);
      n++;
    end
    chk("drain_bound", n < 100, 1);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("overflow", overflow_o, m_ovf);
    chk("done_before", done_o, 0);
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("done_after", done_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    do_reset();
    fork
      monitor();
    join_none
    run(0, MAX_CYCLES, -1, 0);
    finish_run();
    do_reset();
    run(1, MAX_CYCLES, -1, 0);
    finish_run();
    do_reset();
    run(2, MAX_CYCLES, -1, 0);
    finish_run();
    do_reset();
    run(3, MAX_CYCLES + 3, 10, 3);
    finish_run();
    do_reset();
    run(3, 15, -1, 0);
    do_reset();
    run(3, MAX_CYCLES, -1, 0);
    finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_trace_unit.md
# perf_trace_unit

Hardware-side pipeline trace source for the pipelined MIPS CPU. Each active cycle it samples the PC and the hazard-detection stall/flush signals and keeps running stall and flush counters. It packs cycle index, PC and both counts into a trace record and buffers the record in a small FIFO. Records drain to a consumer over a valid/ready stream. The block sits beside the CPU top level, tapping `PC.addr_o` and the HDU/Ctrl outputs, and replaces bench-side per-cycle printing with an in-design record producer.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the cycle, stall, flush and drop counters.
- `MAX_CYCLES`, 30: number of captured cycles before the run ends.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  capture enable; same meaning as the CPU `start`.
- `pc_i`  in  32  current PC (`PC.addr_o`).
- `stall_i`  in  1  HDU stall.
- `flush_i`  in  1  HDU flush.
- `pc_ctrl_i`  in  2  Ctrl PC select; a stall counts only when this is 2'b00.
- `trc_valid_o`  out  1  FIFO head is a valid record.
- `trc_ready_i`  in  1  consumer accepts the head record.
- `trc_cycle_o`  out  CNT_W  cycle index of the head record.
- `trc_pc_o`  out  32  PC of the head record.
- `trc_stall_o`  out  CNT_W  stall count of the head record.
- `trc_flush_o`  out  CNT_W  flush count of the head record.
- `overflow_o`  out  1  sticky flag: at least one record was dropped.
- `drop_cnt_o`  out  CNT_W  number of dropped records, saturating.
- `done_o`  out  1  run complete and FIFO drained.

## Operation
- State machine states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE → RUN on the first edge where `start`=1. That cycle is captured as cycle 0.
- In RUN, a cycle with `start`=1 is a capture cycle:
  - stall counter += 1 if `stall_i` && `pc_ctrl_i`==2'b00;
  - flush counter += 1 if `flush_i`;
  - a record {cycle, `pc_i`, post-update stall count, post-update flush count} is pushed;
  - the cycle counter then increments.
- In RUN, a cycle with `start`=0 captures nothing and all counters hold.
- RUN → DRAIN on the edge that captures cycle index MAX_CYCLES-1.
- DRAIN → DONE when the FIFO is empty. DONE holds until reset.
- All counters saturate at all-ones and never wrap.
- FIFO full with no pop in the same cycle: the record is dropped, `drop_cnt_o` += 1 and `overflow_o` is set.
- FIFO full with a simultaneous pop: the push is accepted.
- Pop happens when `trc_valid_o` && `trc_ready_i`.
- Reset mid-run clears every counter, the FIFO, `overflow_o` and the state machine.

## Timing
- Reset values:
  - `trc_valid_o`=0, `overflow_o`=0, `done_o`=0;
  - `trc_cycle_o`, `trc_pc_o`, `trc_stall_o`, `trc_flush_o` and `drop_cnt_o` all 0.
- Latency: a record captured in cycle N is visible at the FIFO head (`trc_valid_o`=1) in cycle N+1 if the FIFO was empty.
- Head data is stable while `trc_valid_o`=1 and `trc_ready_i`=0.
- The consumer may hold `trc_ready_i` high permanently. With `trc_ready_i` held high, throughput is one record per cycle with no drops.
- `done_o` rises on the edge after the final pop.

## Configuration
- Macro: `PERF_TRACE_FILTER_EN`.
- Defined: a record is pushed only on capture cycles where the stall increment or the flush increment fired. Counters and the cycle index still advance every capture cycle.
- Undefined: every capture cycle pushes a record.

## Structure
- Shared package `perf_trace_pkg` holds:
  - the record struct typedef (cycle, pc, stall, flush);
  - the state enum;
  - the `PC_CTRL_SEQ` = 2'b00 constant.
- One sub-module, `trace_fifo`: a synchronous FIFO parameterised by `DEPTH` and record type, with full/empty flags and simultaneous push/pop support.
- The top level contains the state machine, the counters and the drop logic.

## Test plan
- Free-run: `trc_ready_i`=1, no hazards, PC steps by 4 from 0.
  - Expect 30 records with cycle 0..29 and PC 0..116, all counts 0.
  - Expect `done_o`=1 one cycle after the last pop.
- Stall qualification: `stall_i`=1 at cycles 3 and 4, with `pc_ctrl_i`=00 at cycle 3 and 01 at cycle 4.
  - Expect the stall count in records 3 and 4 to be 1.
- Flush: `flush_i`=1 at cycle 7. Expect records 7..29 to have flush count 1.
- Backpressure: `trc_ready_i`=0 for the whole run, `DEPTH`=8.
  - Expect 8 records held, `drop_cnt_o`=22 and `overflow_o`=1.
  - After releasing ready, expect records 0..7, then `done_o`=1.
- Start gap: `start`=0 for cycles 10-12 of the run.
  - Expect the cycle index to continue at 10 after the gap, and no records during the gap.
- Reset in RUN at cycle 15:
  - all outputs return to reset values;
  - a new `start` restarts at cycle 0.
  - With `PERF_TRACE_FILTER_EN` defined, only the hazard cycles produce records.
